// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared encodings, op enumeration and decoded-instruction record
// for the half-precision FPU decode front end.
package fpu_types_pkg;

    localparam logic [6:0] OPCODE_FOP    = 7'b1010011;
    localparam logic [6:0] OPCODE_FMADD  = 7'b1000011;
    localparam logic [6:0] OPCODE_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPCODE_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPCODE_FNMADD = 7'b1001111;
    localparam logic [6:0] OPCODE_FLOAD  = 7'b0000111;
    localparam logic [6:0] OPCODE_FSTORE = 7'b0100111;

    localparam logic [1:0] FMT_HALF   = 2'b10;
    localparam logic [2:0] WIDTH_HALF = 3'b001;
    localparam logic [2:0] RM_DYN     = 3'b111;

    localparam logic [4:0] FUNCT_FADD    = 5'b00000;
    localparam logic [4:0] FUNCT_FSUB    = 5'b00001;
    localparam logic [4:0] FUNCT_FMUL    = 5'b00010;
    localparam logic [4:0] FUNCT_FDIV    = 5'b00011;
    localparam logic [4:0] FUNCT_FSGNJ   = 5'b00100;
    localparam logic [4:0] FUNCT_FMINMAX = 5'b00101;
    localparam logic [4:0] FUNCT_FSQRT   = 5'b01011;
    localparam logic [4:0] FUNCT_FCOMP   = 5'b10100;
    localparam logic [4:0] FUNCT_FCVTHI  = 5'b11000;
    localparam logic [4:0] FUNCT_FCVTIH  = 5'b11010;
    localparam logic [4:0] FUNCT_FCLASS  = 5'b11100;

    // FOP_NONE is zero so an all-zero record is the idle/reset value
    typedef enum logic [4:0] {
        FOP_NONE  = 5'd0,
        FOP_ADD   = 5'd1,
        FOP_SUB   = 5'd2,
        FOP_MUL   = 5'd3,
        FOP_DIV   = 5'd4,
        FOP_SQRT  = 5'd5,
        FOP_SGNJ  = 5'd6,
        FOP_SGNJN = 5'd7,
        FOP_SGNJX = 5'd8,
        FOP_MIN   = 5'd9,
        FOP_MAX   = 5'd10,
        FOP_EQ    = 5'd11,
        FOP_LT    = 5'd12,
        FOP_LE    = 5'd13,
        FOP_CLASS = 5'd14,
        FOP_CVTWH = 5'd15,
        FOP_CVTHW = 5'd16,
        FOP_MADD  = 5'd17,
        FOP_MSUB  = 5'd18,
        FOP_NMSUB = 5'd19,
        FOP_NMADD = 5'd20,
        FOP_LOAD  = 5'd21,
        FOP_STORE = 5'd22
    } fpu_op_t;

    typedef struct packed {
        fpu_op_t     op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rs3;
        logic [2:0]  rm;
        logic [11:0] imm;
        logic        illegal;
    } fpu_dec_t;

    function automatic logic rm_reserved(input logic [2:0] rm);
        return rm[2] && (rm[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fpu_decode_logic.sv
// fpu_decode_logic: purely combinational decode of one instruction into fpu_dec_t,
// accepting only the half-precision format.
module fpu_decode_logic
    import fpu_types_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  frm,
    output fpu_dec_t    dec
);

    logic [6:0] opcode;
    logic [4:0] funct5;
    logic [4:0] rs2;
    logic [2:0] rm;
    logic [2:0] rm_res;
    logic       half;
    logic       rnd;
    logic       illegal;
    fpu_op_t    op;

    assign opcode = instr[6:0];
    assign funct5 = instr[31:27];
    assign rs2    = instr[24:20];
    assign rm     = instr[14:12];
    assign half   = instr[26:25] == FMT_HALF;

    always_comb begin
        op  = FOP_NONE;
        rnd = 1'b0;
        case (opcode)
            OPCODE_FOP: if (half) begin
                case (funct5)
                    FUNCT_FADD:    begin op = FOP_ADD;   rnd = 1'b1; end
                    FUNCT_FSUB:    begin op = FOP_SUB;   rnd = 1'b1; end
                    FUNCT_FMUL:    begin op = FOP_MUL;   rnd = 1'b1; end
                    FUNCT_FDIV:    begin op = FOP_DIV;   rnd = 1'b1; end
                    FUNCT_FSQRT:   begin op = rs2 == 5'd0 ? FOP_SQRT : FOP_NONE; rnd = 1'b1; end
                    FUNCT_FSGNJ:   op = rm == 3'b000 ? FOP_SGNJ : rm == 3'b001 ? FOP_SGNJN :
                                        rm == 3'b010 ? FOP_SGNJX : FOP_NONE;
                    FUNCT_FMINMAX: op = rm == 3'b000 ? FOP_MIN : rm == 3'b001 ? FOP_MAX : FOP_NONE;
                    FUNCT_FCOMP:   op = rm == 3'b010 ? FOP_EQ : rm == 3'b001 ? FOP_LT :
                                        rm == 3'b000 ? FOP_LE : FOP_NONE;
                    FUNCT_FCLASS:  op = (rm == 3'b001 && rs2 == 5'd0) ? FOP_CLASS : FOP_NONE;
                    FUNCT_FCVTHI:  begin op = FOP_CVTWH; rnd = 1'b1; end
                    FUNCT_FCVTIH:  begin op = FOP_CVTHW; rnd = 1'b1; end
                    default:       op = FOP_NONE;
                endcase
            end
            OPCODE_FMADD:  begin op = half ? FOP_MADD  : FOP_NONE; rnd = 1'b1; end
            OPCODE_FMSUB:  begin op = half ? FOP_MSUB  : FOP_NONE; rnd = 1'b1; end
            OPCODE_FNMSUB: begin op = half ? FOP_NMSUB : FOP_NONE; rnd = 1'b1; end
            OPCODE_FNMADD: begin op = half ? FOP_NMADD : FOP_NONE; rnd = 1'b1; end
            OPCODE_FLOAD:  op = rm == WIDTH_HALF ? FOP_LOAD  : FOP_NONE;
            OPCODE_FSTORE: op = rm == WIDTH_HALF ? FOP_STORE : FOP_NONE;
            default:       op = FOP_NONE;
        endcase
    end

    // Dynamic rounding is resolved here so downstream units see a concrete mode
    assign rm_res  = rm == RM_DYN ? frm : rm;
    assign illegal = op == FOP_NONE || (rnd && rm_reserved(rm_res));

    assign dec.op      = illegal ? FOP_NONE : op;
    assign dec.rd      = instr[11:7];
    assign dec.rs1     = instr[19:15];
    assign dec.rs2     = rs2;
    assign dec.rs3     = funct5;
    assign dec.rm      = rnd ? rm_res : rm;
    assign dec.imm     = opcode == OPCODE_FLOAD  ? instr[31:20] :
                         opcode == OPCODE_FSTORE ? {instr[31:25], instr[11:7]} : 12'd0;
    assign dec.illegal = illegal;

endmodule

// File: rtl/fpu_decode.sv
// fpu_decode: one-cycle FP instruction decoder with output register and optional
// skid register (enabled by macro FPU_DECODE_SKID_EN).
module fpu_decode
    import fpu_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [2:0]  frm,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output fpu_op_t     out_op,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rs3,
    output logic [2:0]  out_rm,
    output logic [11:0] out_imm,
    output logic        out_illegal
);

    fpu_dec_t dec;
    fpu_dec_t out_q;
    fpu_dec_t skid_q;
    logic     out_v;
    logic     skid_v;
    logic     rdy_q;
    logic     acc;
    logic     load_out;
    logic     out_v_n;

    fpu_decode_logic u_logic (
        .instr (in_instr),
        .frm   (frm),
        .dec   (dec)
    );

    assign load_out = !out_v || out_ready;
    assign acc      = in_valid && in_ready;
    assign out_v_n  = flush ? 1'b0 : load_out ? (skid_v || acc) : 1'b1;

`ifdef FPU_DECODE_SKID_EN
    logic skid_v_n;

    assign skid_v_n = flush ? 1'b0 : load_out ? 1'b0 : (skid_v || acc);
    assign in_ready = rdy_q;

    // Ready is registered from the next skid state to keep out_ready off the input path
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_v <= 1'b0;
            skid_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            skid_v <= skid_v_n;
            rdy_q  <= !skid_v_n;
            if (!flush && !load_out && acc)
                skid_q <= dec;
        end
    end
`else
    assign skid_v   = 1'b0;
    assign skid_q   = '0;
    assign in_ready = rdy_q && load_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdy_q <= 1'b0;
        else
            rdy_q <= 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            out_q <= '0;
        end else begin
            out_v <= out_v_n;
            if (!flush && load_out && (skid_v || acc))
                out_q <= skid_v ? skid_q : dec;
        end
    end

    assign out_valid   = out_v;
    assign out_op      = out_q.op;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_rs3     = out_q.rs3;
    assign out_rm      = out_q.rm;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_fpu_decode.sv
// tb_fpu_decode: directed literal checks plus randomized traffic against a queue-based
// behavioural model of the decoder and its buffering.
module tb_fpu_decode;
    import fpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  frm = 3'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic        in_ready;
    logic        out_valid;
    fpu_op_t     out_op;
    logic [4:0]  out_rd, out_rs1, out_rs2, out_rs3;
    logic [2:0]  out_rm;
    logic [11:0] out_imm;
    logic        out_illegal;

    fpu_decode dut (
        .clk(clk), .rst(rst), .flush(flush), .frm(frm),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rs3(out_rs3), .out_rm(out_rm), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        fpu_op_t     op;
        logic [4:0]  rd, rs1, rs2, rs3;
        logic [2:0]  rm;
        logic [11:0] imm;
        logic        ill;
    } exp_t;

    exp_t q[$];
    bit   rdy_ok = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    localparam logic [31:0] INS_A = 32'h042081D3;
    localparam logic [31:0] INS_B = 32'h04208253;
    localparam logic [31:0] INS_C = 32'h042082D3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t ref_dec(input logic [31:0] i, input logic [2:0] f);
        exp_t e;
        logic [6:0] opc = i[6:0];
        logic [2:0] rm = i[14:12];
        logic [4:0] fn = i[31:27];
        logic [4:0] r2 = i[24:20];
        logic half = i[26:25] == 2'b10;
        logic [2:0] eff;
        bit rounding;
        e.op = FOP_NONE;
        if (opc == 7'h53 && half) begin
            if (fn == 5'd0) e.op = FOP_ADD;
            else if (fn == 5'd1) e.op = FOP_SUB;
            else if (fn == 5'd2) e.op = FOP_MUL;
            else if (fn == 5'd3) e.op = FOP_DIV;
            else if (fn == 5'd11 && r2 == 0) e.op = FOP_SQRT;
            else if (fn == 5'd4 && rm < 3) e.op = rm == 0 ? FOP_SGNJ : rm == 1 ? FOP_SGNJN : FOP_SGNJX;
            else if (fn == 5'd5 && rm < 2) e.op = rm == 0 ? FOP_MIN : FOP_MAX;
            else if (fn == 5'd20 && rm < 3) e.op = rm == 0 ? FOP_LE : rm == 1 ? FOP_LT : FOP_EQ;
            else if (fn == 5'd28 && rm == 1 && r2 == 0) e.op = FOP_CLASS;
            else if (fn == 5'd24) e.op = FOP_CVTWH;
            else if (fn == 5'd26) e.op = FOP_CVTHW;
        end else if (half && opc == 7'h43) e.op = FOP_MADD;
        else if (half && opc == 7'h47) e.op = FOP_MSUB;
        else if (half && opc == 7'h4B) e.op = FOP_NMSUB;
        else if (half && opc == 7'h4F) e.op = FOP_NMADD;
        else if (opc == 7'h07 && rm == 1) e.op = FOP_LOAD;
        else if (opc == 7'h27 && rm == 1) e.op = FOP_STORE;
        rounding = e.op inside {FOP_ADD, FOP_SUB, FOP_MUL, FOP_DIV, FOP_SQRT, FOP_MADD,
                                FOP_MSUB, FOP_NMSUB, FOP_NMADD, FOP_CVTWH, FOP_CVTHW};
        eff = rm == 3'd7 ? f : rm;
        e.rm = rounding ? eff : rm;
        e.ill = e.op == FOP_NONE || (rounding && eff >= 3'd5);
        if (e.ill) e.op = FOP_NONE;
        e.rd = i[11:7];
        e.rs1 = i[19:15];
        e.rs2 = r2;
        e.rs3 = fn;
        e.imm = opc == 7'h07 ? i[31:20] : opc == 7'h27 ? {i[31:25], i[11:7]} : 12'd0;
        return e;
    endfunction

    function automatic bit exp_ready();
`ifdef FPU_DECODE_SKID_EN
        return !rst && rdy_ok && q.size() < 2;
`else
        return !rst && rdy_ok && (q.size() == 0 || out_ready);
`endif
    endfunction

    // Model state advances on the same edge the DUT samples its inputs
    always @(posedge clk or posedge rst) begin
        bit acc;
        if (rst) begin
            q.delete();
            rdy_ok = 0;
        end else begin
            acc = in_valid && exp_ready();
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (acc) q.push_back(ref_dec(in_instr, frm));
            end
            rdy_ok = 1;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, exp_ready());
        if (q.size() > 0) begin
            chk("out_op", out_op, q[0].op);
            chk("out_illegal", out_illegal, q[0].ill);
            chk("out_regs_imm", {out_rd, out_rs1, out_rs2, out_rs3, out_imm},
                {q[0].rd, q[0].rs1, q[0].rs2, q[0].rs3, q[0].imm});
            if (!q[0].ill) chk("out_rm", out_rm, q[0].rm);
        end else if (rst) begin
            chk("rst_op", out_op, FOP_NONE);
            chk("rst_fields", {out_rd, out_rs1, out_rs2, out_rs3, out_rm, out_imm, out_illegal}, 0);
        end
    end

    function automatic logic [31:0] rnd_instr();
        logic [31:0] i;
        logic [4:0] fl [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11, 5'd20, 5'd24, 5'd26, 5'd28};
        int k, k2;
        i = $urandom;
        k = $urandom_range(0, 11);
        k2 = $urandom_range(0, 12);
        i[6:0] = k < 5 ? 7'h53 : k == 5 ? 7'h43 : k == 6 ? 7'h47 : k == 7 ? 7'h4B :
                 k == 8 ? 7'h4F : k == 9 ? 7'h07 : k == 10 ? 7'h27 : i[6:0];
        if ($urandom_range(0, 3) != 0) i[26:25] = 2'b10;
        if ($urandom_range(0, 2) == 0) i[24:20] = 5'd0;
        if (k < 5 && k2 < 11) i[31:27] = fl[k2];
        if ((k == 9 || k == 10) && $urandom_range(0, 3) != 0) i[14:12] = 3'b001;
        else if ($urandom_range(0, 2) == 0) i[14:12] = 3'b111;
        return i;
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 0);
        chk("reset out_op", out_op, FOP_NONE);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready after reset", in_ready, 1);
        #1 in_valid = 1'b1; in_instr = INS_A; out_ready = 1'b1; frm = 3'd0;
        @(negedge clk);
        chk("add valid", out_valid, 1);
        chk("add op", out_op, FOP_ADD);
        chk("add regs", {out_rd, out_rs1, out_rs2}, {5'd3, 5'd1, 5'd2});
        chk("add rm", out_rm, 3'b000);
        chk("add illegal", out_illegal, 0);
        #1 in_instr = 32'h002081D3;
        @(negedge clk);
        chk("single fmt illegal", out_illegal, 1);
        chk("single fmt op", out_op, FOP_NONE);
        chk("single fmt valid", out_valid, 1);
        #1 in_instr = 32'h0420F1D3; frm = 3'b001;
        @(negedge clk);
        chk("dyn rm", out_rm, 3'b001);
        chk("dyn legal", out_illegal, 0);
        #1 frm = 3'b101;
        @(negedge clk);
        chk("dyn reserved illegal", out_illegal, 1);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("drained", out_valid, 0);

        // backpressure: A, B, C back to back with out_ready low
        #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = INS_A;
        @(negedge clk);
`ifdef FPU_DECODE_SKID_EN
        #1 in_instr = INS_B;
        @(negedge clk);
        chk("bp ready low after B", in_ready, 0);
        chk("bp head A", out_rd, 5'd3);
        #1 in_instr = INS_C;
        @(negedge clk);
        chk("bp C held", in_ready, 0);
        chk("bp A stable", out_rd, 5'd3);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp B next", out_rd, 5'd4);
        chk("bp B valid", out_valid, 1);
        @(negedge clk);
        chk("bp C last", out_rd, 5'd5);
`else
        chk("bp ready low after A", in_ready, 0);
        chk("bp head A", out_rd, 5'd3);
        #1 in_instr = INS_B;
        @(negedge clk);
        chk("bp A stable", out_rd, 5'd3);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp B next", out_rd, 5'd4);
`endif
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp drained", out_valid, 0);

        // flush with buffered entries and a simultaneous input
        #1 out_ready = 1'b0; in_valid = 1'b1; in_instr = INS_A;
        @(negedge clk);
        #1 in_instr = INS_B;
        @(negedge clk);
        #1 flush = 1'b1; in_instr = INS_C;
        @(negedge clk);
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush nothing emerges", out_valid, 0);
        #1 flush = 1'b1; in_valid = 1'b1; in_instr = INS_A;
        @(negedge clk);
        chk("flush drops accept", out_valid, 0);

        // reset in mid-stream
        #1 flush = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async rst out_valid", out_valid, 0);
        chk("async rst in_ready", in_ready, 0);
        @(negedge clk);
        #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("ready after mid reset", in_ready, 1);
        #1 in_valid = 1'b1; in_instr = INS_B;
        @(negedge clk);
        chk("first after reset", out_rd, 5'd4);
        chk("first after reset valid", out_valid, 1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            in_valid  = $urandom_range(0, 9) < 7;
            out_ready = $urandom_range(0, 9) < ((c % 200) < 100 ? 8 : 3);
            flush     = $urandom_range(0, 49) == 0;
            frm       = 3'($urandom);
            in_instr  = rnd_instr();
            rst       = $urandom_range(0, 999) == 0;
        end
        @(negedge clk);
        #1 rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fpu_decode.md
FPU_DECODE -- requirements
Module: fpu_decode

Interface
- REQ-001: No parameters; all widths come from fpu_types_pkg.
- REQ-002: CLK  in  1  clock; all state updates on its rising edge.
- REQ-003: RST  in  1  reset, asynchronous, active-high.
- REQ-004: flush  in  1  discards all buffered instructions.
- REQ-005: frm  in  3  dynamic rounding mode from the fcsr.
- REQ-006: in_valid  in  1 / in_ready  out  1 / in_instr  in  32  instruction handshake.
- REQ-007: out_valid  out  1 / out_ready  in  1  decoded-op handshake.
- REQ-008: out_op  out  fpu_op_t(5)  decoded operation; FOP_NONE when illegal.
- REQ-009: out_rd, out_rs1, out_rs2, out_rs3  out  5 each  register fields (instr[11:7], [19:15], [24:20], [31:27]).
- REQ-010: out_rm  out  3  resolved rounding mode / sub-op select.
- REQ-011: out_imm  out  12  load/store offset (I-type or S-type field per opcode); 0 otherwise.
- REQ-012: out_illegal  out  1  instruction is not a legal half-precision FP instruction.

Function
- REQ-013: Only the half format is legal: fmt (instr[26:25]) SHALL equal FMT_HALF for OPCODE_FOP and the four FMA opcodes; FLOAD/FSTORE SHALL require width WIDTH_HALF (3'b001).
- REQ-014: OPCODE_FOP decode by funct5: FADD/FSUB/FMUL/FDIV -> FOP_ADD/SUB/MUL/DIV; FSQRT -> FOP_SQRT (rs2 must be 0); FSGNJ with rm 000/001/010 -> FOP_SGNJ/SGNJN/SGNJX; FMINMAX with rm 000/001 -> FOP_MIN/MAX; FCOMP with rm 010/001/000 -> FOP_EQ/LT/LE; FCLASS with rm 001 and rs2 0 -> FOP_CLASS; FCVTHI (11000) -> FOP_CVTWH; FCVTIH (11010) -> FOP_CVTHW; any other combination is illegal.
- REQ-015: FMA opcodes -> FOP_MADD/MSUB/NMSUB/NMADD; FLOAD/FSTORE -> FOP_LOAD/FOP_STORE; any other opcode is illegal.
- REQ-016: Rounding ops (ADD, SUB, MUL, DIV, SQRT, FMA, CVT): rm RM_DYN resolves to frm. A resolved value of 101, 110 or 111 is illegal. For non-rounding ops, out_rm SHALL pass instr[14:12] unchanged.
- REQ-017: An illegal instruction SHALL still be accepted and presented, with out_illegal=1 and out_op=FOP_NONE; it SHALL never stall the pipe.
- REQ-018: Latency SHALL be exactly 1 cycle from input handshake to out_valid when the output is empty.
- REQ-019: Storage is two entries: an output register and a skid register. in_ready SHALL be !skid_valid, driven from a register with no combinational path from out_ready.
- REQ-020: Routing on acceptance:
  - data goes to the output register if it is empty or is being consumed that cycle;
  - otherwise data goes to the skid register;
  - when the output is consumed and the skid is full, the skid entry moves to the output register.
  - Program order SHALL be preserved.
- REQ-021: Sustained throughput SHALL be 1 instruction/cycle when out_ready=1.
- REQ-022: Outputs SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-023: flush SHALL clear both valids on the next edge. An instruction accepted in the flush cycle is dropped. Flush wins over every simultaneous event.

Reset
- REQ-024: While RST=1: out_valid=0, skid empty, in_ready=0. All output data fields SHALL be 0 and out_op SHALL be FOP_NONE.
- REQ-025: in_ready SHALL rise on the first edge after RST falls. A reset mid-operation discards all entries.

Configuration
- REQ-026: Macro FPU_DECODE_SKID_EN.
  - Defined: the behaviour in REQ-019..021 applies.
  - Undefined: no skid register; in_ready = !out_valid || out_ready (combinational), and all other behaviour is unchanged.

Structure
- REQ-027: fpu_types_pkg SHALL hold fpu_op_t (FOP_NONE plus the 22 ops above), WIDTH_HALF=3'b001, FUNCT_FCVTHI=5'b11000 and FUNCT_FCVTIH=5'b11010.
- REQ-028: The combinational decode SHALL be the sub-module fpu_decode_logic (instr, frm -> decoded struct fpu_dec_t, defined in the package). fpu_decode holds only buffering and handshake.

Verification
- REQ-029: Legal add: in_instr=0x042081D3, out_ready=1 -> next cycle out_op=FOP_ADD, rd=3, rs1=1, rs2=2, out_rm=000, out_illegal=0.
- REQ-030: Wrong format: 0x002081D3 (fmt single) -> out_illegal=1, out_op=FOP_NONE, presented after 1 cycle.
- REQ-031: Dynamic rounding: 0x0420F1D3 with frm=001 -> out_rm=001, out_illegal=0. The same instruction with frm=101 -> out_illegal=1.
- REQ-032: Backpressure: out_ready=0 with three back-to-back valid inputs (A, B, C) -> A and B accepted, in_ready=0 from the cycle after B is accepted, C held. Then out_ready=1 -> outputs A, B, C in order, one per cycle.
- REQ-033: Flush: two entries buffered plus flush=1 together with in_valid=1 -> out_valid=0 next cycle, nothing emerges, in_ready=1.
- REQ-034: Reset: RST asserted mid-stream -> out_valid=0 and in_ready=0 immediately; after RST falls, the first output is the first instruction accepted after reset.
